controle_elevador: RTL and testbench
====================================

# controle_elevador

Elevator car controller; sits directly downstream of the access-gated button stage and consumes its 16-bit gated floor-request vector (floors 6–15 already masked by the resident check). Latches requests into a pending register and runs a collective (SCAN) policy: keep moving in the current direction while requests lie ahead, stop and open the door at requested floors, reverse or idle when nothing remains. Drives current floor, direction, motion and door status to the panel/display logic.

## Interface
- N_ANDARES, 16, number of floors; the request vector width.
- T_ANDAR, 8, clock cycles spent in motion per floor (≥2).
- T_PORTA, 4, clock cycles the door stays open (≥1).
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- botaochecado  in  N_ANDARES  gated floor requests; any bit high in a cycle registers that floor (level or pulse).
- parar  in  1  hold: freezes the motion and door timers while high; requests are still latched.
- andar_atual  out  4  current floor, 0..N_ANDARES-1.
- pendentes  out  N_ANDARES  registered outstanding requests.
- subindo  out  1  moving up.
- descendo  out  1  moving down.
- porta_aberta  out  1  door open.

## Operation
- States: OCIOSO (stopped, door closed), MOVENDO, PORTA.
- Reset values: state OCIOSO, andar_atual 0, pendentes 0, direction register = up, timers 0; subindo, descendo and porta_aberta are all 0.
- Request latch: pendentes <= (pendentes | botaochecado) & ~clear. clear is the current-floor bit when the next state is PORTA or the state is already PORTA. Decisions use the registered pendentes only.
- "Ahead" means any pending bit strictly above andar_atual when the direction is up, or strictly below when it is down. "Behind" means the opposite side.
- OCIOSO:
  - Current-floor bit pending → PORTA.
  - Else ahead → MOVENDO, direction kept.
  - Else behind → MOVENDO, direction flipped.
  - Else stay in OCIOSO.
- MOVENDO: timer runs T_ANDAR cycles. On expiry, andar_atual steps ±1 and the next state is chosen in the same edge:
  - New floor pending → PORTA.
  - Else ahead → MOVENDO, timer reloaded.
  - Else behind → flip direction, MOVENDO.
  - Else → OCIOSO.
- PORTA: timer runs T_PORTA cycles.
  - A new request for the current floor during PORTA is absorbed (cleared) and reloads the door timer.
  - On expiry: ahead → MOVENDO; else behind → flip direction, MOVENDO; else → OCIOSO.
- Boundaries:
  - The car never steps below 0 or above N_ANDARES-1, because "ahead" is empty at the extremes.
  - Requests on both sides while idle: the current direction wins.
  - parar high: timers hold and the state does not advance; outputs are unchanged.
  - rst asserted mid-move or with the door open: immediate return to reset values, and all pending requests are lost.
- Output decode: subindo = MOVENDO & up; descendo = MOVENDO & down; porta_aberta = PORTA.

## Timing
- A botaochecado bit high in cycle k is visible in pendentes at cycle k+1.
- Idle car at floor f, request for floor g≠f at cycle k:
  - MOVENDO from cycle k+2.
  - Arrives with andar_atual=g and state PORTA at cycle k+2+|g−f|·T_ANDAR.
  - pendentes[g] is 0 in that same cycle.
- Idle car, request for the current floor at cycle k: PORTA at cycle k+2.
- porta_aberta stays high exactly T_PORTA cycles, extended by parar cycles and reloads. The next state appears on the following edge.
- All outputs are registered or decoded from registered state; there are no combinational paths from inputs to outputs.

## Structure
- Package elevador_pkg holds:
  - the estado_t enum (OCIOSO, MOVENDO, PORTA);
  - the floor-index width constant;
  - the DIR_SOBE/DIR_DESCE encodings.
- Sub-module temporizador: loadable down-counter with load, hold (driven by parar) and done outputs. It is instantiated once and shared by MOVENDO and PORTA, since only one is active at a time.
- Ahead/behind masks are built combinationally from andar_atual via a thermometer compare.

## Test plan
- Reset, then a pulse on botaochecado=0x0008 at cycle 10:
  - subindo from cycle 12;
  - andar_atual=3 and porta_aberta=1 at cycle 36 (T_ANDAR=8);
  - porta_aberta held 4 cycles, then OCIOSO.
- Car at floor 5 moving up with requests 9 and 2 pending: stops at 9, reverses, stops at 2; never passes floor 9.
- Request for floor 0 while idle at 0: porta_aberta 2 cycles later. A second request for floor 0 during the door cycle reloads the door timer, so the door is open for a total of 4 + elapsed cycles.
- parar held for 10 cycles mid-floor: arrival is delayed by exactly 10 cycles. A request arriving during the hold appears in pendentes.
- rst pulsed while moving between floors 4 and 5 with pendentes=0x8010: all outputs return to reset values asynchronously.
- Simultaneous requests 0x8001 from idle at floor 7 after a downward trip: the car goes down to 0 first, then up to 15.

Source files
------------

// File: rtl/elevador_pkg.sv
// Shared types and encodings for the elevator car controller.
package elevador_pkg;

  localparam int ANDAR_W = 4;

  typedef enum logic [1:0] {
    OCIOSO,
    MOVENDO,
    PORTA
  } estado_t;

  localparam logic DIR_SOBE  = 1'b1;
  localparam logic DIR_DESCE = 1'b0;

endpackage

// File: rtl/controle_elevador_temporizador.sv
// Loadable down-counter shared by the per-floor travel time and the door time.
// fim is high while the count sits at zero.
module temporizador #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         carga,
  input  logic         segura,
  input  logic [W-1:0] valor,
  output logic         fim
);

  logic [W-1:0] contagem;

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contagem <= '0;
    end else if (carga) begin
      contagem <= valor;
    end else if (!segura && contagem != '0) begin
      contagem <= contagem - 1'b1;
    end
  end

  assign fim = (contagem == '0);

endmodule

// File: rtl/controle_elevador.sv
// Elevator car controller: latches gated floor requests and serves them with a
// collective (SCAN) policy, driving floor, direction, motion and door status.
module controle_elevador
  import elevador_pkg::*;
#(
  parameter int N_ANDARES = 16,
  parameter int T_ANDAR   = 8,
  parameter int T_PORTA   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_ANDARES-1:0] botaochecado,
  input  logic                 parar,
  output logic [ANDAR_W-1:0]   andar_atual,
  output logic [N_ANDARES-1:0] pendentes,
  output logic                 subindo,
  output logic                 descendo,
  output logic                 porta_aberta
);

  localparam int TMR_MAX = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] CARGA_ANDAR = TMR_W'(T_ANDAR - 1);
  localparam logic [TMR_W-1:0] CARGA_PORTA = TMR_W'(T_PORTA - 1);

  estado_t              estado, prox_estado;
  logic                 direcao, prox_direcao;
  logic [ANDAR_W-1:0]   prox_andar, andar_passo;
  logic [N_ANDARES-1:0] limpa;
  logic                 carga, fim;
  logic [TMR_W-1:0]     valor_carga;

  logic [N_ANDARES-1:0] acima_atual, abaixo_atual, acima_passo, abaixo_passo;
  logic                 frente_atual, tras_atual, frente_passo, tras_passo;

  // Floor one step along the current direction; only used when moving, where
  // a pending request ahead guarantees this stays inside the shaft.
  assign andar_passo = (direcao == DIR_SOBE) ? andar_atual + 1'b1 : andar_atual - 1'b1;

  // Thermometer masks of floors strictly above/below the current and next floor.
  for (genvar i = 0; i < N_ANDARES; i++) begin : g_mascara
    assign acima_atual[i]  = (ANDAR_W'(i) > andar_atual);
    assign abaixo_atual[i] = (ANDAR_W'(i) < andar_atual);
    assign acima_passo[i]  = (ANDAR_W'(i) > andar_passo);
    assign abaixo_passo[i] = (ANDAR_W'(i) < andar_passo);
  end

  assign frente_atual = |(pendentes & ((direcao == DIR_SOBE) ? acima_atual  : abaixo_atual));
  assign tras_atual   = |(pendentes & ((direcao == DIR_SOBE) ? abaixo_atual : acima_atual));
  assign frente_passo = |(pendentes & ((direcao == DIR_SOBE) ? acima_passo  : abaixo_passo));
  assign tras_passo   = |(pendentes & ((direcao == DIR_SOBE) ? abaixo_passo : acima_passo));

  temporizador #(.W(TMR_W)) u_temporizador (
    .clk    (clk),
    .rst    (rst),
    .carga  (carga),
    .segura (parar),
    .valor  (valor_carga),
    .fim    (fim)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    prox_estado  = estado;
    prox_direcao = direcao;
    prox_andar   = andar_atual;
    carga        = 1'b0;
    valor_carga  = CARGA_ANDAR;

    if (!parar) begin
      unique case (estado)
        OCIOSO: begin
          if (pendentes[andar_atual]) begin
            prox_estado = PORTA;
            carga       = 1'b1;
            valor_carga = CARGA_PORTA;
          end else if (frente_atual) begin
            prox_estado = MOVENDO;
            carga       = 1'b1;
          end else if (tras_atual) begin
            prox_estado  = MOVENDO;
            prox_direcao = ~direcao;
            carga        = 1'b1;
          end
        end

        MOVENDO: begin
          if (fim) begin
            prox_andar = andar_passo;
            carga      = 1'b1;
            if (pendentes[andar_passo]) begin
              prox_estado = PORTA;
              valor_carga = CARGA_PORTA;
            end else if (frente_passo) begin
              prox_estado = MOVENDO;
            end else if (tras_passo) begin
              prox_direcao = ~direcao;
            end else begin
              prox_estado = OCIOSO;
              carga       = 1'b0;
            end
          end
        end

        PORTA: begin
          // A fresh call for this floor keeps the door open another full period.
          if (botaochecado[andar_atual]) begin
            carga       = 1'b1;
            valor_carga = CARGA_PORTA;
          end else if (fim) begin
            if (frente_atual) begin
              prox_estado = MOVENDO;
              carga       = 1'b1;
            end else if (tras_atual) begin
              prox_estado  = MOVENDO;
              prox_direcao = ~direcao;
              carga        = 1'b1;
            end else begin
              prox_estado = OCIOSO;
            end
          end
        end

        default: prox_estado = OCIOSO;
      endcase
    end
  end

  // The served floor is cleared on the edge that opens the door and on every
  // door cycle, which absorbs repeat presses while the door is open.
  always_comb begin
    limpa = '0;
    if (estado == PORTA) begin
      limpa[andar_atual] = 1'b1;
    end else if (prox_estado == PORTA) begin
      limpa[prox_andar] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= OCIOSO;
      direcao     <= DIR_SOBE;
      andar_atual <= '0;
      pendentes   <= '0;
    end else begin
      estado      <= prox_estado;
      direcao     <= prox_direcao;
      andar_atual <= prox_andar;
      pendentes   <= (pendentes | botaochecado) & ~limpa;
    end
  end

  assign subindo      = (estado == MOVENDO) && (direcao == DIR_SOBE);
  assign descendo     = (estado == MOVENDO) && (direcao == DIR_DESCE);
  assign porta_aberta = (estado == PORTA);

endmodule

// File: tb/tb_controle_elevador.sv
// Scoreboard bench for controle_elevador: a behavioural car model predicts each
// cycle's outputs and every door opening; a monitor compares what the DUT shows.
module tb_controle_elevador;

  localparam int N       = 16;
  localparam int T_ANDAR = 8;
  localparam int T_PORTA = 4;

  localparam int PH_STOP   = 0;
  localparam int PH_TRAVEL = 1;
  localparam int PH_DOOR   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  botaochecado = '0;
  logic          parar = 1'b0;
  logic [3:0]    andar_atual;
  logic [N-1:0]  pendentes;
  logic          subindo, descendo, porta_aberta;

  controle_elevador #(
    .N_ANDARES (N),
    .T_ANDAR   (T_ANDAR),
    .T_PORTA   (T_PORTA)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .botaochecado (botaochecado),
    .parar        (parar),
    .andar_atual  (andar_atual),
    .pendentes    (pendentes),
    .subindo      (subindo),
    .descendo     (descendo),
    .porta_aberta (porta_aberta)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   floor;
    logic [N-1:0] pend;
    logic         sub;
    logic         desc;
    logic         door;
  } snap_t;

  snap_t snap_q[$];
  int    door_q[$];

  int n_checks = 0;
  int n_err    = 0;
  int n_snap   = 0;
  int max_floor;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dut_snap();
    snap_t s;
    s.floor = andar_atual;
    s.pend  = pendentes;
    s.sub   = subindo;
    s.desc  = descendo;
    s.door  = porta_aberta;
    return 32'(s);
  endfunction

  // ---------------- behavioural car model ----------------
  int           m_floor = 0;
  bit           m_up    = 1'b1;
  int           m_phase = PH_STOP;
  int           m_left  = 0;
  logic [N-1:0] m_pend  = '0;

  function automatic bit has_side(input logic [N-1:0] p, input int f, input bit above);
    for (int i = 0; i < N; i++)
      if (p[i] && (above ? (i > f) : (i < f))) return 1'b1;
    return 1'b0;
  endfunction

  task automatic decide(input logic [N-1:0] pb, input bit allow_door);
    if (allow_door && pb[m_floor]) begin
      m_phase = PH_DOOR;
      m_left  = T_PORTA;
    end else if (has_side(pb, m_floor, m_up)) begin
      m_phase = PH_TRAVEL;
      m_left  = T_ANDAR;
    end else if (has_side(pb, m_floor, !m_up)) begin
      m_up    = !m_up;
      m_phase = PH_TRAVEL;
      m_left  = T_ANDAR;
    end else begin
      m_phase = PH_STOP;
    end
  endtask

  task automatic model_step(input logic [N-1:0] b, input logic hold);
    logic [N-1:0] pb;
    bit           was_door;
    snap_t        s;
    pb       = m_pend;
    was_door = (m_phase == PH_DOOR);
    if (!hold) begin
      case (m_phase)
        PH_STOP: decide(pb, 1'b1);
        PH_TRAVEL: begin
          m_left--;
          if (m_left == 0) begin
            m_floor = m_up ? m_floor + 1 : m_floor - 1;
            decide(pb, 1'b1);
          end
        end
        default: begin
          if (b[m_floor]) m_left = T_PORTA;
          else begin
            m_left--;
            if (m_left == 0) decide(pb, 1'b0);
          end
        end
      endcase
    end
    m_pend = pb | b;
    if (m_phase == PH_DOOR || was_door) m_pend[m_floor] = 1'b0;
    if (m_phase == PH_DOOR && !was_door) door_q.push_back(m_floor);
    s.floor = 4'(m_floor);
    s.pend  = m_pend;
    s.sub   = (m_phase == PH_TRAVEL) && m_up;
    s.desc  = (m_phase == PH_TRAVEL) && !m_up;
    s.door  = (m_phase == PH_DOOR);
    snap_q.push_back(s);
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_floor = 0;
      m_up    = 1'b1;
      m_phase = PH_STOP;
      m_left  = 0;
      m_pend  = '0;
      snap_q.delete();
      door_q.delete();
    end else begin
      model_step(botaochecado, parar);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic prev_door;
    snap_t exp_s;
    prev_door = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("reset_outputs", dut_snap(), 32'd0);
        prev_door = 1'b0;
      end else begin
        if (snap_q.size() > 0) begin
          exp_s = snap_q.pop_front();
          n_snap++;
          check("cycle_outputs", dut_snap(), 32'(exp_s));
        end
        if (porta_aberta && !prev_door) begin
          if (door_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL door_floor: door opened at floor %0d, no opening expected", andar_atual);
          end else begin
            check("door_floor", 32'(andar_atual), 32'(door_q.pop_front()));
          end
        end
        prev_door = porta_aberta;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    botaochecado = '0;
    parar        = 1'b0;
    rst          = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_door(input int budget, output int floor);
    logic was;
    floor = -1;
    was   = porta_aberta;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (int'(andar_atual) > max_floor) max_floor = int'(andar_atual);
      if (porta_aberta && !was) begin
        floor = int'(andar_atual);
        return;
      end
      was = porta_aberta;
    end
    n_checks++;
    n_err++;
    $display("FAIL door_wait: no door opening within %0d cycles", budget);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int f1, f2, f3;

    // Request for floor 3 from idle at floor 0.
    do_reset();
    repeat (9) tick();
    check("reset_floor", 32'(andar_atual), 32'd0);
    botaochecado = 16'h0008;
    for (int c = 1; c <= 30; c++) begin
      tick();
      botaochecado = '0;
      if (c == 1) begin
        check("t1_pend_visible", 32'(pendentes), 32'h0008);
        check("t1_not_yet_moving", 32'(subindo), 32'd0);
      end
      if (c == 2)  check("t1_subindo", 32'(subindo), 32'd1);
      if (c == 25) check("t1_before_arrival", {andar_atual, porta_aberta}, {4'd2, 1'b0});
      if (c == 26) check("t1_arrival", {andar_atual, porta_aberta, pendentes}, {4'd3, 1'b1, 16'h0000});
      if (c >= 27 && c <= 29) check("t1_door_held", 32'(porta_aberta), 32'd1);
      if (c == 30) check("t1_idle_after_door", {porta_aberta, subindo, descendo}, 3'b000);
    end

    // Current-floor request, then a repeat press that reloads the door timer.
    do_reset();
    tick();
    botaochecado = 16'h0001;
    for (int c = 1; c <= 8; c++) begin
      tick();
      botaochecado = (c == 3) ? 16'h0001 : 16'h0000;
      if (c == 1) check("t2_door_not_yet", 32'(porta_aberta), 32'd0);
      if (c == 2) check("t2_door_opens", 32'(porta_aberta), 32'd1);
      if (c == 4) check("t2_repeat_absorbed", 32'(pendentes), 32'd0);
      if (c == 7) check("t2_door_extended", 32'(porta_aberta), 32'd1);
      if (c == 8) check("t2_door_closes", 32'(porta_aberta), 32'd0);
    end

    // Hold for 10 cycles mid-floor on the way to floor 2; a call to 9 arrives meanwhile.
    do_reset();
    tick();
    botaochecado = 16'h0004;
    for (int c = 1; c <= 28; c++) begin
      tick();
      parar        = (c >= 5 && c < 15);
      botaochecado = (c == 8) ? 16'h0200 : 16'h0000;
      if (c == 9)  check("t3_pend_during_hold", 32'(pendentes), 32'h0204);
      if (c == 14) check("t3_frozen", {andar_atual, subindo}, {4'd0, 1'b1});
      if (c == 27) check("t3_delayed", {andar_atual, porta_aberta}, {4'd1, 1'b0});
      if (c == 28) check("t3_arrival", {andar_atual, porta_aberta}, {4'd2, 1'b1});
    end

    // Moving up past 5 toward 9, a call for 2 appears: serve 9, then reverse to 2.
    do_reset();
    max_floor = 0;
    tick();
    botaochecado = 16'h0200;
    for (int c = 1; c <= 45; c++) begin
      tick();
      if (c == 44) check("t4_at_five_up", {andar_atual, subindo}, {4'd5, 1'b1});
      botaochecado = (c == 44) ? 16'h0004 : 16'h0000;
    end
    wait_door(200, f1);
    wait_door(200, f2);
    check("t4_first_stop", 32'(f1), 32'd9);
    check("t4_second_stop", 32'(f2), 32'd2);
    check("t4_never_past_9", 32'(max_floor), 32'd9);

    // Asynchronous reset while moving from 4 to 5 with two calls pending.
    do_reset();
    tick();
    botaochecado = 16'h8000;
    for (int c = 1; c <= 37; c++) begin
      tick();
      botaochecado = (c == 36) ? 16'h0010 : 16'h0000;
      if (c == 37) check("t5_moving_4_5", {andar_atual, subindo, pendentes}, {4'd4, 1'b1, 16'h8010});
    end
    #2 rst = 1'b1;
    #1 check("t5_async_reset", dut_snap(), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Idle at 7 after a downward trip; calls at 0 and 15: down first.
    do_reset();
    tick();
    botaochecado = 16'h0100;
    tick();
    botaochecado = '0;
    wait_door(200, f1);
    check("t6_first_at_8", 32'(f1), 32'd8);
    repeat (5) tick();
    botaochecado = 16'h0080;
    tick();
    botaochecado = '0;
    wait_door(100, f1);
    check("t6_down_to_7", 32'(f1), 32'd7);
    repeat (5) tick();
    botaochecado = 16'h8001;
    tick();
    botaochecado = '0;
    tick();
    check("t6_goes_down", {subindo, descendo}, 2'b01);
    wait_door(200, f2);
    wait_door(300, f3);
    check("t6_stop_0_first", 32'(f2), 32'd0);
    check("t6_then_15", 32'(f3), 32'd15);

    // Random traffic with holds, repeat presses and occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (rst) rst = 1'b0;
      case ($urandom_range(0, 15))
        0:       botaochecado = N'(1) << $urandom_range(0, N - 1);
        1:       botaochecado = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
        default: botaochecado = '0;
      endcase
      if (porta_aberta && $urandom_range(0, 3) == 0)
        botaochecado = botaochecado | (N'(1) << andar_atual);
      parar = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 799) == 0) begin
        #2 rst = 1'b1;
        #1 check("rand_async_reset", dut_snap(), 32'd0);
      end
    end
    botaochecado = '0;
    parar        = 1'b0;
    rst          = 1'b0;
    tick();
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(snap_q.size() + door_q.size()), 32'd0);
    check("snapshots_compared", 32'(n_snap > 1000), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
